// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_window_gen
//  Brief    : Raster pixel stream to 3x3 windows, one per interior pixel.
//             Optional luma front end: define SOBEL_WIN_GRAY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_window_gen #(
  parameter int MAX_WIDTH = 1024,
  parameter int PIX_W     = 8,
  parameter int COORD_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          cfg_width,
  input  logic                 pix_valid_in,
  input  logic                 sof_in,
  input  logic [23:0]          pix_in,
  output logic                 win_valid,
  output logic [9*PIX_W-1:0]   win_data,
  output logic [COORD_W-1:0]   win_x,
  output logic [COORD_W-1:0]   win_y,
  output logic                 cfg_err
);

  localparam int          AW      = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [15:0] MAX_W16 = 16'(MAX_WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, ERROR = 2'd2} state_t;

  logic              s_valid;
  logic              s_sof;
  logic [PIX_W-1:0]  s_g;
  logic [15:0]       s_width;

`ifdef SOBEL_WIN_GRAY_EN
  logic              pipe_valid_q, pipe_valid_d;
  logic              pipe_sof_q, pipe_sof_d;
  logic [PIX_W-1:0]  pipe_g_q, pipe_g_d;
  logic [15:0]       pipe_width_q, pipe_width_d;

  // Weights sum to 256, so equal channels map to themselves.
  always_comb begin
    pipe_valid_d = pix_valid_in;
    pipe_sof_d   = sof_in;
    pipe_width_d = cfg_width;
    pipe_g_d     = PIX_W'((16'd77  * {8'd0, pix_in[7:0]}
                         + 16'd150 * {8'd0, pix_in[15:8]}
                         + 16'd29  * {8'd0, pix_in[23:16]}) >> 8);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid_q <= 1'b0;
      pipe_sof_q   <= 1'b0;
      pipe_g_q     <= '0;
      pipe_width_q <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_sof_q   <= pipe_sof_d;
      pipe_g_q     <= pipe_g_d;
      pipe_width_q <= pipe_width_d;
    end
  end

  assign s_valid = pipe_valid_q;
  assign s_sof   = pipe_sof_q;
  assign s_g     = pipe_g_q;
  assign s_width = pipe_width_q;
`else
  logic unused_pix_bits;
  assign unused_pix_bits = ^pix_in[23:PIX_W];
  assign s_valid = pix_valid_in;
  assign s_sof   = sof_in;
  assign s_g     = pix_in[PIX_W-1:0];
  assign s_width = cfg_width;
`endif

  state_t                   state_q, state_d;
  logic [15:0]              width_q, width_d;
  logic [15:0]              x_q, x_d;
  logic [COORD_W-1:0]       y_q, y_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     win_valid_q, win_valid_d;
  logic [8:0][PIX_W-1:0]    win_data_q, win_data_d;
  logic [8:0][PIX_W-1:0]    shift_q, shift_d;
  logic [COORD_W-1:0]       win_x_q, win_x_d;
  logic [COORD_W-1:0]       win_y_q, win_y_d;

  // Rows y-2 and y-1 of the current frame, indexed by column.
  logic [PIX_W-1:0] lb_top_mem [MAX_WIDTH];
  logic [PIX_W-1:0] lb_mid_mem [MAX_WIDTH];

  logic              accept;
  logic              width_ok;
  logic [15:0]       cur_x;
  logic [15:0]       cur_w;
  logic [COORD_W-1:0] cur_y;
  logic [PIX_W-1:0]  top_pix;
  logic [PIX_W-1:0]  mid_pix;

  assign width_ok = (s_width >= 16'd3) && (s_width <= MAX_W16);

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    x_d         = x_q;
    y_d         = y_q;
    cfg_err_d   = cfg_err_q;
    win_valid_d = 1'b0;
    win_data_d  = win_data_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    shift_d     = shift_q;
    accept      = 1'b0;
    cur_x       = x_q;
    cur_y       = y_q;
    cur_w       = width_q;

    if (s_valid) begin
      if (s_sof) begin
        cur_x = '0;
        cur_y = '0;
        cur_w = s_width;
        if (width_ok) begin
          state_d = ACTIVE;
          width_d = s_width;
          accept  = 1'b1;
        end else begin
          state_d   = ERROR;
          cfg_err_d = 1'b1;
        end
      end else if (state_q == ACTIVE) begin
        accept = 1'b1;
      end
    end

    top_pix = lb_top_mem[cur_x[AW-1:0]];
    mid_pix = lb_mid_mem[cur_x[AW-1:0]];

    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        shift_d[r*3+0] = shift_q[r*3+1];
        shift_d[r*3+1] = shift_q[r*3+2];
      end
      shift_d[2] = top_pix;
      shift_d[5] = mid_pix;
      shift_d[8] = s_g;

      if (cur_x == cur_w - 16'd1) begin
        x_d = '0;
        y_d = (cur_y == '1) ? cur_y : cur_y + COORD_W'(1);
      end else begin
        x_d = cur_x + 16'd1;
        y_d = cur_y;
      end

      if ((cur_x >= 16'd2) && (cur_y >= COORD_W'(2))) begin
        win_valid_d = 1'b1;
        win_data_d  = shift_d;
        win_x_d     = COORD_W'(cur_x - 16'd1);
        win_y_d     = cur_y - COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      width_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cfg_err_q   <= 1'b0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      shift_q     <= '0;
      win_x_q     <= '0;
      win_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cfg_err_q   <= cfg_err_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      shift_q     <= shift_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top_mem[cur_x[AW-1:0]] <= mid_pix;
      lb_mid_mem[cur_x[AW-1:0]] <= s_g;
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign cfg_err   = cfg_err_q;

endmodule
`default_nettype wire
